shift_left_seq: RTL

- Sequencing controller for the combinational 8-lane x 12-bit `shift_left` datapath.
- That datapath only reports a valid result for per-pass shifts of 0..5 lanes.
- This block accepts arbitrary lane shifts (0..31) over a valid/ready interface and splits each one into legal passes of at most 5 lanes.
- It iterates the shift on a registered 96-bit word, then presents the result with backpressure.
- It sits between a request source and any consumer of lane-shifted words.

---
 rtl/shift_seq_pkg.sv | 45 ++++
 rtl/shift_left.sv | 40 ++++
 rtl/shift_left_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift_left_seq controller and its
// shift_left datapath.
//
// Contents:
//   - lane geometry (LANE_W, LANES, DATA_W)
//   - MAX_STEP: largest lane shift the datapath accepts in one pass
//   - CLAMP:    requested shifts at or above this value clear every lane
//   - state_t:  controller states {IDLE, SHIFT, DONE}
//   - helper functions for shift clamping and per-pass step selection
package shift_seq_pkg;

  localparam int LANE_W   = 12;
  localparam int LANES    = 8;
  localparam int DATA_W   = LANE_W * LANES;
  localparam int MAX_STEP = 5;
  localparam int SHIFT_W  = 5;
  localparam int CLAMP    = 8;
  // remaining holds 0..CLAMP, a single pass step holds 0..7
  localparam int REM_W    = 4;
  localparam int STEP_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Any shift of CLAMP lanes or more leaves nothing but fill, so larger
  // requests are reduced to CLAMP to bound the number of passes.
  function automatic logic [REM_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
    if (s >= SHIFT_W'(CLAMP)) begin
      return REM_W'(CLAMP);
    end
    return s[REM_W-1:0];
  endfunction

  // Lanes moved in the next pass: everything that is left, up to MAX_STEP.
  function automatic logic [STEP_W-1:0] step_of(input logic [REM_W-1:0] rem);
    if (rem > REM_W'(MAX_STEP)) begin
      return STEP_W'(MAX_STEP);
    end
    return rem[STEP_W-1:0];
  endfunction

endpackage

// File: rtl/shift_left.sv
// Combinational lane-shift datapath.
//
// Shifts a LANES x LANE_W word left by `shift` whole lanes, filling the
// vacated low lanes with `fill`. The result is only guaranteed meaningful
// for shifts 0..MAX_STEP; `valid` reports whether the requested shift is
// inside that range.
//
// Ports:
//   data   in  DATA_W  word to shift; lane k = bits [LANE_W*k +: LANE_W]
//   shift  in  STEP_W  lane shift for this pass
//   fill   in  LANE_W  pattern written into vacated lanes
//   result out DATA_W  shifted word
//   valid  out 1       shift is within 0..MAX_STEP
module shift_left
  import shift_seq_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [STEP_W-1:0] shift,
  input  logic [LANE_W-1:0] fill,
  output logic [DATA_W-1:0] result,
  output logic              valid
);

  logic [LANE_W-1:0] lanes [LANES];

  assign valid = (shift <= STEP_W'(MAX_STEP));

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [STEP_W:0] src;

      assign lanes[gi] = data[gi*LANE_W +: LANE_W];
      // Source lane index gi - shift; the extra MSB goes high when the
      // subtraction underflows, i.e. this lane was vacated.
      assign src = (STEP_W+1)'(gi) - {1'b0, shift};
      assign result[gi*LANE_W +: LANE_W] = src[STEP_W] ? fill : lanes[src[STEP_W-1:0]];
    end
  endgenerate

endmodule

// File: rtl/shift_left_seq.sv
// Sequencing controller for the shift_left datapath.
//
// Accepts a lane shift of 0..31 over valid/ready, clamps it to 8 and
// applies it to a registered word in passes of at most MAX_STEP lanes,
// then presents the result with backpressure. One transaction in flight.
//
// Ports:
//   clk        in  1        clock
//   rst        in  1        synchronous active-high reset
//   in_valid   in  1        request valid
//   in_ready   out 1        request can be accepted (IDLE)
//   in_data    in  96       word to shift
//   in_shift   in  SHIFT_W  total lane shift
//   in_fill    in  12       fill lane pattern
//   out_valid  out 1        result valid (DONE)
//   out_ready  in  1        consumer accepts result
//   out_data   out 96       shifted result
//   perf_done  out 16       saturating count of output handshakes
//                           (only when SHIFT_LEFT_SEQ_PERF_EN is defined)
//
// Optional feature macro: SHIFT_LEFT_SEQ_PERF_EN
module shift_left_seq
  import shift_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [SHIFT_W-1:0]  in_shift,
  input  logic [LANE_W-1:0]   in_fill,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef SHIFT_LEFT_SEQ_PERF_EN
  output logic [15:0]         perf_done,
`endif
  output logic [DATA_W-1:0]   out_data
);

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   work_reg, work_next;
  logic [LANE_W-1:0]   fill_reg, fill_next;
  logic [REM_W-1:0]    rem_reg, rem_next;
  logic [STEP_W-1:0]   step;
  logic [DATA_W-1:0]   dp_data;
  logic                dp_valid;
  logic [REM_W-1:0]    clamped;

  assign step    = step_of(rem_reg);
  assign clamped = clamp_shift(in_shift);

  shift_left u_shift_left (
    .data   (work_reg),
    .shift  (step),
    .fill   (fill_reg),
    .result (dp_data),
    .valid  (dp_valid)
  );

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_data  = work_reg;

  always_comb begin
    state_next = state_reg;
    work_next  = work_reg;
    fill_next  = fill_reg;
    rem_next   = rem_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          work_next  = in_data;
          fill_next  = in_fill;
          rem_next   = clamped;
          state_next = (clamped == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_next = dp_data;
        rem_next  = rem_reg - REM_W'(step);
        if (rem_reg == REM_W'(step)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      fill_reg  <= '0;
      rem_reg   <= '0;
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      fill_reg  <= fill_next;
      rem_reg   <= rem_next;
    end
  end

`ifdef SHIFT_LEFT_SEQ_PERF_EN
  logic [15:0] perf_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_reg <= '0;
    end else if (out_valid && out_ready && (perf_reg != 16'hFFFF)) begin
      perf_reg <= perf_reg + 16'd1;
    end
  end

  assign perf_done = perf_reg;
`endif

endmodule
